// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch unit
package fetch_pkg;

   localparam int INSTR_BYTES      = 4;
   localparam int FETCH_PC_WIDTH   = 32;
   localparam int FETCH_DATA_WIDTH = 32;

   typedef struct packed {
      logic [FETCH_PC_WIDTH-1:0]   pc;
      logic [FETCH_DATA_WIDTH-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry fetch queue with registered head, flush and count
import fetch_pkg::*;

module fetch_buffer (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         flush_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  fetch_entry_t push_entry_i,
   output fetch_entry_t head_o,
   output logic [1:0]   count_o
);

   fetch_entry_t head_q, head_d;
   fetch_entry_t tail_q, tail_d;
   logic [1:0]   count_q, count_d;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         count_d = 2'd0;
      end else begin
         case ({push_i, pop_i})
            2'b10: begin
               if (count_q == 2'd0) head_d = push_entry_i;
               else                 tail_d = push_entry_i;
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               head_d  = tail_q;
               count_d = count_q - 2'd1;
            end
            2'b11: begin
               // A lone entry is replaced directly; with two, the tail moves up.
               if (count_q == 2'd1) begin
                  head_d = push_entry_i;
               end else begin
                  head_d = tail_q;
                  tail_d = push_entry_i;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign head_o  = head_q;
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC generation, in-flight tracking, issue and redirect
import fetch_pkg::*;

module fetch_unit #(
   parameter int                ADDR_WIDTH = 8,
   parameter int                DATA_WIDTH = FETCH_DATA_WIDTH,
   parameter int                PC_WIDTH   = FETCH_PC_WIDTH,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   output logic [ADDR_WIDTH-1:0] imem_addr_o,
   input  logic [DATA_WIDTH-1:0] imem_data_i,
   input  logic                  redirect_valid_i,
   input  logic [PC_WIDTH-1:0]   redirect_pc_i,
   output logic                  instr_valid_o,
   input  logic                  instr_ready_i,
   output logic [DATA_WIDTH-1:0] instr_o,
   output logic [PC_WIDTH-1:0]   instr_pc_o
);

   logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [PC_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                inflight_q, inflight_d;
   logic [PC_WIDTH-1:0] cur_pc;
   logic [1:0]          buf_count;
   logic [2:0]          count_next;
   logic                pop, push, issue;
   fetch_entry_t        head;
   logic                unused_redirect_lsbs;

   assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

   assign cur_pc      = redirect_valid_i ? {redirect_pc_i[PC_WIDTH-1:2], 2'b00} : fetch_pc_q;
   assign imem_addr_o = rst_i ? RESET_PC[ADDR_WIDTH+1:2] : cur_pc[ADDR_WIDTH+1:2];

   assign instr_valid_o = (buf_count != 2'd0) & ~redirect_valid_i;
   assign pop           = instr_valid_o & instr_ready_i;

   // Only issue when the response arriving next cycle is guaranteed a free slot.
   assign count_next = {1'b0, buf_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue      = (count_next < 3'd2);
   assign push       = inflight_q & ~redirect_valid_i;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = 1'b0;
      if (redirect_valid_i) begin
         inflight_d    = 1'b1;
         inflight_pc_d = cur_pc;
         fetch_pc_d    = cur_pc + PC_WIDTH'(INSTR_BYTES);
      end else if (issue) begin
         inflight_d    = 1'b1;
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + PC_WIDTH'(INSTR_BYTES);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fetch_pc_q    <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_buffer u_buf (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .flush_i      (redirect_valid_i),
      .push_i       (push),
      .pop_i        (pop),
      .push_entry_i ('{pc: inflight_pc_q, instr: imem_data_i}),
      .head_o       (head),
      .count_o      (buf_count)
   );

   assign instr_o    = head.instr;
   assign instr_pc_o = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit with ROM and in-order PC scoreboard
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [7:0]  imem_addr_o;
   logic [31:0] imem_data_i;
   logic        redirect_valid_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;

   logic [31:0] rom [256];
   logic [31:0] exp_pc;
   logic [7:0]  held_addr;
   int          total = 0;
   int          bad = 0;
   int          delivered = 0;
   int          rand_start;

   fetch_unit #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .PC_WIDTH(32), .RESET_PC(RST_PC)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .imem_addr_o      (imem_addr_o),
      .imem_data_i      (imem_data_i),
      .redirect_valid_i (redirect_valid_i),
      .redirect_pc_i    (redirect_pc_i),
      .instr_valid_o    (instr_valid_o),
      .instr_ready_i    (instr_ready_i),
      .instr_o          (instr_o),
      .instr_pc_o       (instr_pc_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data_i <= rom[imem_addr_o];

   function automatic logic [31:0] rom_at(input logic [31:0] pc);
      return rom[(pc / 4) % 256];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic settle();
      #1;
   endtask

   // Mid-cycle sampling: reference stream of PCs, restarted by reset or redirect.
   task automatic tick();
      @(negedge clk);
      if (rst_i) begin
         chk("rst_addr", 32'(imem_addr_o), (RST_PC / 4) % 256);
         exp_pc = RST_PC;
      end else if (redirect_valid_i) begin
         chk("redir_valid", 32'(instr_valid_o), 32'd0);
         chk("redir_addr", 32'(imem_addr_o), (redirect_pc_i / 4) % 256);
         exp_pc = (redirect_pc_i / 4) * 4;
      end else if (instr_valid_o && instr_ready_i) begin
         chk("sb_pc", instr_pc_o, exp_pc);
         chk("sb_instr", instr_o, rom_at(exp_pc));
         exp_pc = exp_pc + 32'd4;
         delivered++;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) rom[i] = $urandom;
      rom[0] = 32'h00000013;
      rom[1] = 32'h00100093;
      rom[2] = 32'h00200113;
      rom[3] = 32'h00300193;
      exp_pc           = RST_PC;
      rst_i            = 1'b1;
      redirect_valid_i = 1'b0;
      redirect_pc_i    = 32'h0;
      instr_ready_i    = 1'b1;
      repeat (3) tick();

      // reset release: valid two cycles later, then 0,4,8,C
      rst_i = 1'b0;
      settle();
      chk("reset_valid", 32'(instr_valid_o), 32'd0);
      chk("reset_instr", instr_o, 32'd0);
      chk("reset_pc", instr_pc_o, 32'd0);
      tick();
      chk("lat_cycle1_valid", 32'(instr_valid_o), 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         chk("stream_valid", 32'(instr_valid_o), 32'd1);
         chk("stream_pc", instr_pc_o, 32'(4 * i));
         chk("stream_instr", instr_o, rom[i]);
         tick();
      end

      // stall: queue saturates, address holds
      instr_ready_i = 1'b0;
      repeat (2) tick();
      held_addr = imem_addr_o;
      for (int i = 0; i < 3; i++) begin
         chk("stall_count", 32'(dut.buf_count), 32'd2);
         chk("stall_addr_hold", 32'(imem_addr_o), 32'(held_addr));
         tick();
      end
      instr_ready_i = 1'b1;
      repeat (8) tick();

      // redirect while two entries are buffered
      instr_ready_i = 1'b0;
      repeat (3) tick();
      chk("full_count", 32'(dut.buf_count), 32'd2);
      instr_ready_i    = 1'b1;
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h40;
      settle();
      chk("redir_full_addr", 32'(imem_addr_o), 32'd16);
      tick();
      redirect_valid_i = 1'b0;
      settle();
      chk("redir_gap_valid", 32'(instr_valid_o), 32'd0);
      tick();
      chk("redir_first_valid", 32'(instr_valid_o), 32'd1);
      chk("redir_first_pc", instr_pc_o, 32'h40);
      chk("redir_first_instr", instr_o, rom[16]);
      tick();
      chk("redir_second_pc", instr_pc_o, 32'h44);
      chk("redir_second_instr", instr_o, rom[17]);
      repeat (3) tick();

      // misaligned redirect coinciding with a would-be pop
      chk("misalign_pre_count", 32'(dut.buf_count != 2'd0), 32'd1);
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h42;
      settle();
      chk("misalign_addr", 32'(imem_addr_o), 32'd16);
      chk("misalign_no_pop", 32'(instr_valid_o), 32'd0);
      tick();
      redirect_valid_i = 1'b0;
      tick();
      chk("misalign_pc", instr_pc_o, 32'h40);
      chk("misalign_instr", instr_o, rom[16]);
      repeat (2) tick();

      // word-address wrap across 0x3FC -> 0x400
      redirect_valid_i = 1'b1;
      redirect_pc_i    = 32'h3FC;
      settle();
      chk("wrap_addr_255", 32'(imem_addr_o), 32'd255);
      tick();
      redirect_valid_i = 1'b0;
      settle();
      chk("wrap_addr_0", 32'(imem_addr_o), 32'd0);
      tick();
      chk("wrap_pc_3fc", instr_pc_o, 32'h3FC);
      chk("wrap_instr_255", instr_o, rom[255]);
      tick();
      chk("wrap_pc_400", instr_pc_o, 32'h400);
      chk("wrap_instr_0", instr_o, rom[0]);
      repeat (2) tick();

      // mid-stream reset with buffered and in-flight data
      chk("midrst_pre_inflight", 32'(dut.inflight_q), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      settle();
      chk("midrst_valid0", 32'(instr_valid_o), 32'd0);
      tick();
      chk("midrst_valid1", 32'(instr_valid_o), 32'd0);
      tick();
      chk("midrst_first_valid", 32'(instr_valid_o), 32'd1);
      chk("midrst_first_pc", instr_pc_o, RST_PC);
      chk("midrst_first_instr", instr_o, rom_at(RST_PC));
      tick();

      // random ready/redirect traffic against the PC-stream scoreboard
      rand_start = delivered;
      for (int i = 0; i < 400; i++) begin
         instr_ready_i    = ($urandom_range(0, 3) != 0);
         redirect_valid_i = ($urandom_range(0, 15) == 0);
         redirect_pc_i    = $urandom;
         tick();
         chk("rand_count_bound", 32'(dut.buf_count <= 2'd2), 32'd1);
      end
      redirect_valid_i = 1'b0;
      instr_ready_i    = 1'b1;
      repeat (4) tick();
      chk("rand_progress", 32'((delivered - rand_start) > 100), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
